// File: rtl/serdes_tx_align_serializer.sv
// Serializer for a SerDes transmit lane. It sends a training burst first, then
// payload words, filler words or a PRBS7 pattern, LSB first.
// Optional feature macro: SERDES_TX_PRBS_EN adds the PRBS7 test-pattern
// generator. Without it, prbs_mode is accepted and ignored.
module serdes_tx_align_serializer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TRAIN_WORDS = 16
) (
  input  logic                  bitclk,
  input  logic                  tx_reset,
  input  logic                  enable,
  input  logic                  train_req,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  prbs_mode,
  output logic                  txclk,
  output logic                  trained,
  output logic                  txp,
  output logic                  txn
);

  localparam int unsigned CntW      = $clog2(DATA_WIDTH);
  localparam int unsigned TrainCntW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

  localparam logic [DATA_WIDTH-1:0] FillWord  = {(DATA_WIDTH / 8){8'h55}};
  localparam logic [DATA_WIDTH-1:0] TrainWord = {FillWord[DATA_WIDTH-1:8], 8'hBC};

  localparam logic [CntW-1:0]      LastBit   = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0]      HalfBit   = CntW'(DATA_WIDTH / 2);
  localparam logic [TrainCntW-1:0] LastTrain = TrainCntW'(TRAIN_WORDS - 1);

  typedef enum logic [1:0] {StOff, StTrain, StData} state_e;

  state_e                state_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [TrainCntW-1:0]  train_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;

  logic                  boundary;
  logic                  prbs_active;
  logic [DATA_WIDTH-1:0] prbs_word;

  assign boundary = (bit_cnt_q == LastBit);

`ifdef SERDES_TX_PRBS_EN
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  assign prbs_active = prbs_mode && (state_q == StData);

  // Advance PRBS7 (x^7 + x^6 + 1) by one whole word; bit i is the i-th new bit.
  always_comb begin
    lfsr_d    = lfsr_q;
    prbs_word = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      prbs_word[i] = lfsr_d[6] ^ lfsr_d[5];
      lfsr_d       = {lfsr_d[5:0], prbs_word[i]};
    end
  end

  // LFSR is held at its seed outside DATA, so every PRBS run starts identically.
  always_ff @(posedge bitclk or posedge tx_reset) begin
    if (tx_reset) begin
      lfsr_q <= 7'h7F;
    end else if (!enable || (state_q != StData) || (boundary && train_req)) begin
      lfsr_q <= 7'h7F;
    end else if (boundary && prbs_mode) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_prbs_mode;

  assign unused_prbs_mode = prbs_mode;
  assign prbs_active      = 1'b0;
  assign prbs_word        = '0;
`endif

  // Lane FSM, bit counter, training-word counter and output shift register.
  always_ff @(posedge bitclk or posedge tx_reset) begin
    if (tx_reset) begin
      state_q     <= StOff;
      bit_cnt_q   <= '0;
      train_cnt_q <= '0;
      shreg_q     <= '0;
    end else if (!enable) begin
      // Electrical idle wins over everything; any partial word is dropped.
      state_q     <= StOff;
      bit_cnt_q   <= '0;
      train_cnt_q <= '0;
      shreg_q     <= '0;
    end else if (state_q == StOff) begin
      state_q     <= StTrain;
      bit_cnt_q   <= '0;
      train_cnt_q <= '0;
      shreg_q     <= TrainWord;
    end else if (!boundary) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
      shreg_q   <= shreg_q >> 1;
    end else begin
      bit_cnt_q <= '0;
      if (state_q == StTrain) begin
        if (train_cnt_q == LastTrain) begin
          state_q     <= StData;
          train_cnt_q <= '0;
          shreg_q     <= FillWord;
        end else begin
          train_cnt_q <= train_cnt_q + 1'b1;
          shreg_q     <= TrainWord;
        end
      end else if (train_req) begin
        state_q     <= StTrain;
        train_cnt_q <= '0;
        shreg_q     <= TrainWord;
      end else if (prbs_active) begin
        shreg_q <= prbs_word;
      end else if (tx_valid) begin
        shreg_q <= tx_data;
      end else begin
        shreg_q <= FillWord;
      end
    end
  end

  assign trained  = (state_q == StData);
  assign tx_ready = (state_q == StData) && boundary && !train_req && !prbs_active;
  assign txclk    = (state_q != StOff) && (bit_cnt_q < HalfBit);
  assign txp      = (state_q != StOff) && shreg_q[0];
  assign txn      = (state_q != StOff) && !shreg_q[0];

endmodule

// File: tb/tb_serdes_tx_align_serializer.sv
// Randomized bench for serdes_tx_align_serializer with a word-level reference
// model feeding a per-cycle expectation queue checked by a separate monitor.
module tb_serdes_tx_align_serializer;

  localparam int DW = 8;
  localparam int TW = 4;

`ifdef SERDES_TX_PRBS_EN
  localparam bit PrbsEn = 1'b1;
`else
  localparam bit PrbsEn = 1'b0;
`endif

  localparam logic [DW-1:0] Fill  = 8'h55;
  localparam logic [DW-1:0] Train = 8'hBC;

  logic          bitclk    = 1'b0;
  logic          tx_reset  = 1'b1;
  logic          enable    = 1'b0;
  logic          train_req = 1'b0;
  logic [DW-1:0] tx_data   = '0;
  logic          tx_valid  = 1'b0;
  logic          prbs_mode = 1'b0;
  logic          tx_ready;
  logic          txclk;
  logic          trained;
  logic          txp;
  logic          txn;

  int checks   = 0;
  int failures = 0;

  always #5 bitclk = ~bitclk;

  serdes_tx_align_serializer #(
    .DATA_WIDTH (DW),
    .TRAIN_WORDS(TW)
  ) dut (
    .bitclk   (bitclk),
    .tx_reset (tx_reset),
    .enable   (enable),
    .train_req(train_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .prbs_mode(prbs_mode),
    .txclk    (txclk),
    .trained  (trained),
    .txp      (txp),
    .txn      (txn)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // PRBS7 reference sequence from the polynomial, seed 7'h7F.
  logic prbs_seq[127];
  initial begin
    logic [6:0] s;
    s = 7'h7F;
    for (int k = 0; k < 127; k++) begin
      prbs_seq[k] = s[6] ^ s[5];
      s = {s[5:0], prbs_seq[k]};
    end
  end

  // Reference model: lane mode, current word and bit position within it.
  typedef struct {
    logic txp;
    logic txn;
    logic txclk;
    logic trained;
    logic last;
    logic data;
  } exp_t;

  exp_t          sb[$];
  bit            started = 1'b0;
  int            m_st    = 0;  // 0 idle, 1 training, 2 data
  int            m_pos   = 0;
  int            m_tw    = 0;
  int            m_pidx  = 0;
  logic [DW-1:0] m_word  = '0;

  task automatic model_step();
    if (!enable) begin
      m_st = 0; m_pos = 0; m_tw = 0; m_word = '0;
    end else if (m_st == 0) begin
      m_st = 1; m_pos = 0; m_tw = 0; m_word = Train;
    end else if (m_pos < DW - 1) begin
      m_pos++;
    end else begin
      m_pos = 0;
      if (m_st == 1) begin
        m_tw++;
        if (m_tw == TW) begin
          m_st = 2; m_word = Fill;
        end else begin
          m_word = Train;
        end
      end else if (train_req) begin
        m_st = 1; m_tw = 0; m_word = Train;
      end else if (PrbsEn && prbs_mode) begin
        for (int i = 0; i < DW; i++) m_word[i] = prbs_seq[(m_pidx + i) % 127];
        m_pidx = (m_pidx + DW) % 127;
      end else if (tx_valid) begin
        m_word = tx_data;
      end else begin
        m_word = Fill;
      end
    end
    if (m_st != 2) m_pidx = 0;
  endtask

  always @(posedge bitclk or posedge tx_reset) begin
    exp_t e;
    if (tx_reset) begin
      m_st = 0; m_pos = 0; m_tw = 0; m_pidx = 0; m_word = '0;
    end else begin
      model_step();
    end
    if (bitclk) begin
      e.txp     = (m_st != 0) && m_word[m_pos];
      e.txn     = (m_st != 0) && !m_word[m_pos];
      e.txclk   = (m_st != 0) && (m_pos < DW / 2);
      e.trained = (m_st == 2);
      e.last    = (m_pos == DW - 1);
      e.data    = (m_st == 2);
      sb.push_back(e);
      started = 1'b1;
    end
  end

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge bitclk) begin
    exp_t e;
    logic rdy_exp;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      rdy_exp = e.data && e.last && !train_req && !(PrbsEn && prbs_mode);
      check("txp", txp, e.txp);
      check("txn", txn, e.txn);
      check("txclk", txclk, e.txclk);
      check("trained", trained, e.trained);
      check("tx_ready", tx_ready, rdy_exp);
    end else if (started) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty at %0t: got no entry expected one", $time);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_txp"}, txp, 1'b0);
    check({tag, "_txn"}, txn, 1'b0);
    check({tag, "_txclk"}, txclk, 1'b0);
    check({tag, "_tx_ready"}, tx_ready, 1'b0);
    check({tag, "_trained"}, trained, 1'b0);
  endtask

  initial begin
    bit got;
    #1 check_all_zero("reset");
    repeat (3) @(posedge bitclk);
    @(negedge bitclk);
    #2 tx_reset = 1'b0;
    repeat (6) @(posedge bitclk);

    // Training burst then idle filler.
    #1 enable = 1'b1;
    repeat (45) @(posedge bitclk);

    // Single payload word, then filler.
    #1 tx_valid = 1'b1;
    tx_data = 8'hA5;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge bitclk);
      if (tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ready_timeout: got no tx_ready expected one within 40 cycles");
    end
    @(posedge bitclk);
    #1 tx_valid = 1'b0;
    repeat (20) @(posedge bitclk);

    // Randomized traffic, retraining requests, PRBS windows and lane drops.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge bitclk);
      #1;
      tx_valid  = ($urandom_range(9) < 7);
      tx_data   = DW'($urandom);
      train_req = ($urandom_range(149) == 0);
      if ($urandom_range(299) == 0) prbs_mode = ~prbs_mode;
      if (enable && $urandom_range(599) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(7) == 0) enable = 1'b1;
    end

    // Asynchronous reset in the middle of DATA.
    #1 train_req = 1'b0;
    prbs_mode = 1'b0;
    enable = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge bitclk);
      if (trained) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL trained_timeout: got trained=0 expected 1 within 200 cycles");
    end
    repeat (3) @(posedge bitclk);
    @(negedge bitclk);
    #2 tx_reset = 1'b1;
    enable = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(posedge bitclk);
    @(negedge bitclk);
    #2 tx_reset = 1'b0;
    repeat (6) @(posedge bitclk);
    #1 enable = 1'b1;

    // Long PRBS window with payload offered throughout.
    repeat (40) @(posedge bitclk);
    #1 prbs_mode = 1'b1;
    tx_valid = 1'b1;
    repeat (400) @(posedge bitclk);
    #1 prbs_mode = 1'b0;
    repeat (40) @(posedge bitclk);

    @(negedge bitclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
